// File: rtl/jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module   : jtag_scan_master
// Brief    : Bus-side IEEE 1149.1 TAP sequencer (IR scan, DR scan, TAP reset).
// Options  : JTAG_SCAN_MASTER_RUNTEST_EN adds cmd_idle Run-Test/Idle dwell.
// Revision : 1.0
// ============================================================================
module jtag_scan_master #(
   parameter int MAX_LEN = 32,
   parameter int CLK_DIV = 2,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SCAN_MASTER_RUNTEST_EN
   input  logic [7:0]         cmd_idle,
`endif
   output logic               resp_valid,
   output logic               resp_err,
   output logic [MAX_LEN-1:0] resp_data,
   output logic               busy,
   output logic               TCK,
   output logic               TMS,
   output logic               TDI,
   input  logic               TDO
);

   localparam int CNT_W = $clog2(MAX_LEN + 264);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [1:0] OP_IR   = 2'b00;
   localparam logic [1:0] OP_RST  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;
   localparam logic [1:0] ST_REJ  = 2'b11;

   logic [1:0]         r_state;
   logic [1:0]         r_op;
   logic [LEN_W-1:0]   r_len;
   logic [MAX_LEN-1:0] r_data;
   logic [MAX_LEN-1:0] r_cap;
   logic [7:0]         r_idle;
   logic [CNT_W-1:0]   r_cnt;
   logic [DIV_W-1:0]   r_div;
   logic               r_tck;
   logic               r_tms;
   logic               r_tdi;
   logic               r_ready;
   logic               r_busy;
   logic               r_resp_valid;
   logic               r_resp_err;
   logic               r_resp_en;
   logic [MAX_LEN-1:0] r_resp_data;

   logic [CNT_W-1:0]   w_pre;
   logic [CNT_W-1:0]   w_sh_end;
   logic [CNT_W-1:0]   w_total;
   logic [CNT_W-1:0]   w_nxt;
   logic [IDX_W-1:0]   w_bit;
   logic [IDX_W-1:0]   w_nxt_bit;
   logic               w_in_shift;
   logic               w_nxt_tms;
   logic               w_nxt_tdi;
   logic               w_half;
   logic               w_reject;
   logic [7:0]         w_idle_in;

`ifdef JTAG_SCAN_MASTER_RUNTEST_EN
   assign w_idle_in = cmd_idle;
`else
   assign w_idle_in = 8'd0;
`endif

   // r_cnt indexes TCK cycles of the current sequence; TMS/TDI for cycle
   // r_cnt+1 are precomputed so they can be launched on the falling edge.
   always_comb begin
      w_pre      = (r_op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
      w_sh_end   = w_pre + CNT_W'(r_len);
      w_total    = (r_op == OP_RST) ? CNT_W'(6)
                                    : w_sh_end + CNT_W'(2) + CNT_W'(r_idle);
      w_nxt      = r_cnt + CNT_W'(1);
      w_in_shift = (r_op != OP_RST) && (r_cnt >= w_pre) && (r_cnt < w_sh_end);
      w_bit      = IDX_W'(r_cnt - w_pre);
      w_nxt_bit  = IDX_W'(w_nxt - w_pre);
      w_half     = (r_div == DIV_W'(CLK_DIV - 1));
      w_nxt_tms  = 1'b0;
      w_nxt_tdi  = 1'b0;
      if (r_op == OP_RST) begin
         w_nxt_tms = (w_nxt < CNT_W'(5));
      end else if (w_nxt < w_pre) begin
         w_nxt_tms = (r_op == OP_IR) && (w_nxt < CNT_W'(2));
      end else if (w_nxt < w_sh_end) begin
         w_nxt_tms = (w_nxt == w_sh_end - CNT_W'(1));
         w_nxt_tdi = r_data[w_nxt_bit];
      end else begin
         w_nxt_tms = (w_nxt == w_sh_end);
      end
      w_reject = (cmd_op == OP_RSVD) ||
                 ((cmd_op != OP_RST) &&
                  ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN))));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= ST_RUN;
         r_op         <= OP_RST;
         r_len        <= '0;
         r_data       <= '0;
         r_idle       <= '0;
         r_cnt        <= '0;
         r_div        <= '0;
         r_tck        <= 1'b0;
         r_tms        <= 1'b1;
         r_tdi        <= 1'b0;
         r_ready      <= 1'b0;
         r_busy       <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_data  <= '0;
         r_cap        <= '0;
         r_resp_en    <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_ready <= 1'b0;
                  if (w_reject) begin
                     r_state      <= ST_REJ;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_data  <= '0;
                  end else begin
                     r_state   <= ST_RUN;
                     r_op      <= cmd_op;
                     r_len     <= cmd_len;
                     r_data    <= cmd_data;
                     r_idle    <= w_idle_in;
                     r_busy    <= 1'b1;
                     r_cnt     <= '0;
                     r_div     <= '0;
                     r_tms     <= 1'b1;
                     r_tdi     <= 1'b0;
                     r_cap     <= '0;
                     r_resp_en <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_half) begin
                  r_div <= '0;
                  r_tck <= ~r_tck;
                  if (!r_tck) begin
                     if (w_in_shift) begin
                        r_cap[w_bit] <= TDO;
                     end
                  end else if (w_nxt == w_total) begin
                     r_state <= ST_DONE;
                     r_tms   <= 1'b0;
                     r_tdi   <= 1'b0;
                  end else begin
                     r_cnt <= w_nxt;
                     r_tms <= w_nxt_tms;
                     r_tdi <= w_nxt_tdi;
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               // The power-on TRST has no requester, so it stays silent.
               if (r_resp_en) begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b0;
                  r_resp_data  <= r_cap;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready  = r_ready;
   assign busy       = r_busy;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_data  = r_resp_data;
   assign TCK        = r_tck;
   assign TMS        = r_tms;
   assign TDI        = r_tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_scan_master
// Brief    : Directed self-checking bench for jtag_scan_master with a TAP model.
// Revision : 1.0
// ============================================================================
module tb_jtag_scan_master;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [5:0]  cmd_len = 6'd0;
   logic [31:0] cmd_data = 32'd0;
`ifdef JTAG_SCAN_MASTER_RUNTEST_EN
   logic [7:0]  cmd_idle = 8'd0;
`endif
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_data;
   logic        busy;
   logic        TCK;
   logic        TMS;
   logic        TDI;
   logic        TDO;

   jtag_scan_master #(.MAX_LEN(32), .CLK_DIV(2)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_len    (cmd_len),
      .cmd_data   (cmd_data),
`ifdef JTAG_SCAN_MASTER_RUNTEST_EN
      .cmd_idle   (cmd_idle),
`endif
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_data  (resp_data),
      .busy       (busy),
      .TCK        (TCK),
      .TMS        (TMS),
      .TDI        (TDI),
      .TDO        (TDO)
   );

   always #5 CLK = ~CLK;

   // TAP model: 4-bit IR capturing 4'b0001, every DR is the 1-bit BYPASS.
   localparam logic [3:0] T_TLR = 4'd0,  T_RTI = 4'd1,  T_SDR = 4'd2,  T_CDR = 4'd3;
   localparam logic [3:0] T_SHDR = 4'd4, T_E1DR = 4'd5, T_PDR = 4'd6,  T_E2DR = 4'd7;
   localparam logic [3:0] T_UDR = 4'd8,  T_SIR = 4'd9,  T_CIR = 4'd10, T_SHIR = 4'd11;
   localparam logic [3:0] T_E1IR = 4'd12, T_PIR = 4'd13, T_E2IR = 4'd14, T_UIR = 4'd15;

   logic [3:0] tap_st  = T_TLR;
   logic [3:0] tap_ir  = 4'hF;
   logic [3:0] ir_sr   = 4'h0;
   logic       dr_sr   = 1'b0;
   logic       tap_tdo = 1'b1;

   assign TDO = tap_tdo;

   always @(posedge TCK) begin
      case (tap_st)
         T_TLR:  begin tap_ir <= 4'hF; tap_st <= TMS ? T_TLR : T_RTI; end
         T_RTI:  tap_st <= TMS ? T_SDR : T_RTI;
         T_SDR:  tap_st <= TMS ? T_SIR : T_CDR;
         T_CDR:  begin dr_sr <= 1'b0; tap_st <= TMS ? T_E1DR : T_SHDR; end
         T_SHDR: begin dr_sr <= TDI; tap_st <= TMS ? T_E1DR : T_SHDR; end
         T_E1DR: tap_st <= TMS ? T_UDR : T_PDR;
         T_PDR:  tap_st <= TMS ? T_E2DR : T_PDR;
         T_E2DR: tap_st <= TMS ? T_UDR : T_SHDR;
         T_UDR:  tap_st <= TMS ? T_SDR : T_RTI;
         T_SIR:  tap_st <= TMS ? T_TLR : T_CIR;
         T_CIR:  begin ir_sr <= 4'b0001; tap_st <= TMS ? T_E1IR : T_SHIR; end
         T_SHIR: begin ir_sr <= {TDI, ir_sr[3:1]}; tap_st <= TMS ? T_E1IR : T_SHIR; end
         T_E1IR: tap_st <= TMS ? T_UIR : T_PIR;
         T_PIR:  tap_st <= TMS ? T_E2IR : T_PIR;
         T_E2IR: tap_st <= TMS ? T_UIR : T_SHIR;
         default: begin tap_ir <= ir_sr; tap_st <= TMS ? T_SDR : T_RTI; end
      endcase
   end

   always @(negedge TCK) begin
      tap_tdo <= (tap_st == T_SHIR) ? ir_sr[0] : (tap_st == T_SHDR) ? dr_sr : 1'b1;
   end

   // Pin monitor, sampled 1 ns after each CLK rise.
   int          cyc      = 0;
   int          rises    = 0;
   int          falls    = 0;
   int          fall_cyc = 0;
   int          resp_cnt = 0;
   logic        prev_tck = 1'b0;
   logic [63:0] tms_hist = 64'd0;
   logic [63:0] tdi_hist = 64'd0;

   always @(posedge CLK) begin
      #1;
      cyc = cyc + 1;
      if (!prev_tck && TCK) begin
         rises    = rises + 1;
         tms_hist = {tms_hist[62:0], TMS};
         tdi_hist = {tdi_hist[62:0], TDI};
      end
      if (prev_tck && !TCK) begin
         falls    = falls + 1;
         fall_cyc = cyc;
      end
      if (resp_valid) resp_cnt = resp_cnt + 1;
      prev_tck = TCK;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 500) begin tick(); n++; end
      chk(tag, 64'(cmd_ready), 64'd1);
   endtask

   task automatic wait_resp(input string tag);
      int n = 0;
      while (resp_valid !== 1'b1 && n < 3000) begin tick(); n++; end
      chk(tag, 64'(resp_valid), 64'd1);
   endtask

   // Offers one command while cmd_ready is high, then scrambles the inputs.
   task automatic do_cmd(input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input logic [7:0] idle);
      cmd_op    = op;
      cmd_len   = len;
      cmd_data  = data;
`ifdef JTAG_SCAN_MASTER_RUNTEST_EN
      cmd_idle  = idle;
`endif
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_data  = ~data;
      cmd_len   = 6'($urandom_range(1, 32));
`ifdef JTAG_SCAN_MASTER_RUNTEST_EN
      cmd_idle  = ~idle;
`endif
   endtask

   int rb;
   int eb;
   int rcb;
   int rel;

   initial begin
      // Reset values.
      repeat (3) tick();
      chk("rst_tck", 64'(TCK), 64'd0);
      chk("rst_tms", 64'(TMS), 64'd1);
      chk("rst_tdi", 64'(TDI), 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_resp_data", 64'(resp_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd1);

      // Power-on TRST: five TMS=1 cycles then one TMS=0.
      rb  = rises;
      rcb = resp_cnt;
      RST = 1'b0;
      rel = cyc;
      wait_ready("trst_ready_timeout");
      chk("trst_latency", 64'(cyc - rel - 1), 64'd24);
      chk("trst_rises", 64'(rises - rb), 64'd6);
      chk("trst_tms", 64'(tms_hist[5:0]), 64'(6'b111110));
      chk("trst_ready_after_fall", 64'(cyc - fall_cyc), 64'd1);
      chk("trst_no_resp", 64'(resp_cnt - rcb), 64'd0);
      chk("trst_busy", 64'(busy), 64'd0);
      chk("trst_tap_rti", 64'(tap_st), 64'(T_RTI));
      rb = rises;
      repeat (10) tick();
      chk("idle_tck_quiet", 64'(rises - rb), 64'd0);
      chk("idle_tck_low", 64'(TCK), 64'd0);

      // IR scan len=4, data F -> BYPASS; IR capture 0001.
      rb = rises;
      do_cmd(2'b00, 6'd4, 32'h0000_000F, 8'd0);
      chk("ir_ready_drop", 64'(cmd_ready), 64'd0);
      wait_resp("ir_resp_timeout");
      chk("ir_rises", 64'(rises - rb), 64'd10);
      chk("ir_tms", 64'(tms_hist[9:0]), 64'(10'b1100000110));
      chk("ir_tdi", 64'(tdi_hist[9:0]), 64'(10'b0000111100));
      chk("ir_data", 64'(resp_data), 64'h1);
      chk("ir_err", 64'(resp_err), 64'd0);
      chk("ir_resp_after_fall", 64'(cyc - fall_cyc), 64'd1);
      chk("ir_ready_with_resp", 64'(cmd_ready), 64'd1);
      chk("ir_tap_ir", 64'(tap_ir), 64'hF);
      chk("ir_tap_rti", 64'(tap_st), 64'(T_RTI));
      tick();
      chk("ir_resp_pulse", 64'(resp_valid), 64'd0);
      chk("ir_data_hold", 64'(resp_data), 64'h1);

      // DR scan len=8 through BYPASS.
      rb = rises;
      do_cmd(2'b01, 6'd8, 32'h0000_00A5, 8'd0);
      wait_resp("dr8_resp_timeout");
      chk("dr8_rises", 64'(rises - rb), 64'd13);
      chk("dr8_tms", 64'(tms_hist[12:0]), 64'(13'b1000000000110));
      chk("dr8_tdi", 64'(tdi_hist[12:0]), 64'(13'b0001010010100));
      chk("dr8_data", 64'(resp_data), 64'h4A);
      chk("dr8_err", 64'(resp_err), 64'd0);

      // Single-bit DR scan: the only shift bit carries TMS=1.
      rb = rises;
      do_cmd(2'b01, 6'd1, 32'h0000_0001, 8'd0);
      wait_resp("dr1_resp_timeout");
      chk("dr1_rises", 64'(rises - rb), 64'd6);
      chk("dr1_tms", 64'(tms_hist[5:0]), 64'(6'b100110));
      chk("dr1_tdi", 64'(tdi_hist[5:0]), 64'(6'b000100));
      chk("dr1_data", 64'(resp_data), 64'h0);

      // Full-width DR scan.
      rb = rises;
      do_cmd(2'b01, 6'd32, 32'hDEAD_BEEF, 8'd0);
      wait_resp("dr32_resp_timeout");
      chk("dr32_rises", 64'(rises - rb), 64'd37);
      chk("dr32_data", 64'(resp_data), 64'hBD5B_7DDE);
      chk("dr32_tap_rti", 64'(tap_st), 64'(T_RTI));

      // Rejected commands: len 0, len 33, reserved op.
      rb = rises;
      eb = falls;
      do_cmd(2'b01, 6'd0, 32'h1234_5678, 8'd0);
      chk("rej_len0_valid", 64'(resp_valid), 64'd1);
      chk("rej_len0_err", 64'(resp_err), 64'd1);
      wait_ready("rej_len0_ready_timeout");
      do_cmd(2'b00, 6'd33, 32'h1234_5678, 8'd0);
      chk("rej_len33_valid", 64'(resp_valid), 64'd1);
      chk("rej_len33_err", 64'(resp_err), 64'd1);
      wait_ready("rej_len33_ready_timeout");
      do_cmd(2'b11, 6'd4, 32'h1234_5678, 8'd0);
      chk("rej_op3_valid", 64'(resp_valid), 64'd1);
      chk("rej_op3_err", 64'(resp_err), 64'd1);
      wait_ready("rej_op3_ready_timeout");
      repeat (4) tick();
      chk("rej_no_tck_edges", 64'((rises - rb) + (falls - eb)), 64'd0);
      chk("rej_tap_rti", 64'(tap_st), 64'(T_RTI));

      // TAP reset command ignores len and answers with zero data.
      rb = rises;
      do_cmd(2'b10, 6'd0, 32'hFFFF_FFFF, 8'd0);
      wait_resp("trst_cmd_resp_timeout");
      chk("trst_cmd_rises", 64'(rises - rb), 64'd6);
      chk("trst_cmd_tms", 64'(tms_hist[5:0]), 64'(6'b111110));
      chk("trst_cmd_err", 64'(resp_err), 64'd0);
      chk("trst_cmd_data", 64'(resp_data), 64'd0);
      chk("trst_cmd_after_fall", 64'(cyc - fall_cyc), 64'd1);

      // RST during shift bit 3 of a 14-bit DR scan.
      rb  = rises;
      rcb = resp_cnt;
      do_cmd(2'b01, 6'd14, 32'h0000_3FFF, 8'd0);
      for (int n = 0; n < 200 && (rises - rb) < 7; n++) tick();
      chk("midrst_reach_bit3", 64'(rises - rb), 64'd7);
      RST = 1'b1;
      tick();
      chk("midrst_tck", 64'(TCK), 64'd0);
      chk("midrst_tms", 64'(TMS), 64'd1);
      chk("midrst_ready", 64'(cmd_ready), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd1);
      chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
      rb  = rises;
      RST = 1'b0;
      wait_ready("midrst_ready_timeout");
      chk("midrst_trst_rises", 64'(rises - rb), 64'd6);
      chk("midrst_trst_tms", 64'(tms_hist[5:0]), 64'(6'b111110));
      chk("midrst_no_resp", 64'(resp_cnt - rcb), 64'd0);
      chk("midrst_tap_rti", 64'(tap_st), 64'(T_RTI));

`ifdef JTAG_SCAN_MASTER_RUNTEST_EN
      // Extra Run-Test/Idle dwell after UPDATE.
      rb = rises;
      do_cmd(2'b01, 6'd1, 32'h0000_0000, 8'd3);
      wait_resp("idle_resp_timeout");
      chk("idle_rises", 64'(rises - rb), 64'd9);
      chk("idle_tms", 64'(tms_hist[8:0]), 64'(9'b100110000));
      chk("idle_after_fall", 64'(cyc - fall_cyc), 64'd1);
      chk("idle_err", 64'(resp_err), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
